mc_control_fsm: RTL and testbench

//  Multi-cycle main control FSM for the MIPS32 datapath. It sequences fetch, decode, execute, memory and writeback

---
 rtl/mc_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional: define MC_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes instead of treating them as NOPs.
module mc_control_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        ext_sel,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal_op,
    output logic [31:0] instr_retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REX    = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] BEQEX  = 4'd8;
    localparam logic [3:0] JEX    = 4'd9;
    localparam logic [3:0] AIMMEX = 4'd10;
    localparam logic [3:0] IMMWB  = 4'd11;
    localparam logic [3:0] LIMMEX = 4'd12;
    localparam logic [3:0] LIMMWB = 4'd13;
    localparam logic [3:0] TRAP   = 4'd14;

    logic [3:0]  state_r;
    logic [3:0]  state_next_s;
    logic [31:0] retired_r;
    logic [31:0] retired_next_s;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= FETCH;
            retired_r <= 32'd0;
        end else begin
            state_r   <= state_next_s;
            retired_r <= retired_next_s;
        end
    end

    // Next-state selection; memory states stall on mem_ready.
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH:  if (mem_ready) state_next_s = DECODE; else state_next_s = FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_next_s = MEMADR;
                    OP_RTYPE:         state_next_s = REX;
                    OP_BEQ:           state_next_s = BEQEX;
                    OP_J:             state_next_s = JEX;
                    OP_ADDI:          state_next_s = AIMMEX;
                    OP_ANDI, OP_ORI:  state_next_s = LIMMEX;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:          state_next_s = TRAP;
`else
                    default:          state_next_s = FETCH;
`endif
                endcase
            end
            MEMADR: if (opcode == OP_SW) state_next_s = MEMWR; else state_next_s = MEMRD;
            MEMRD:  if (mem_ready) state_next_s = MEMWB; else state_next_s = MEMRD;
            MEMWR:  if (mem_ready) state_next_s = FETCH; else state_next_s = MEMWR;
            REX:    state_next_s = RWB;
            AIMMEX: state_next_s = IMMWB;
            LIMMEX: state_next_s = LIMMWB;
            TRAP:   state_next_s = TRAP;
            default: state_next_s = FETCH;
        endcase
    end

    // A retirement is any edge that re-enters FETCH; the counter wraps freely.
    always_comb begin
        if ((state_next_s == FETCH) && (state_r != FETCH)) begin
            retired_next_s = retired_r + 32'd1;
        end else begin
            retired_next_s = retired_r;
        end
    end

    // Output decode from state; only FETCH and MEMWB strobes look at mem_ready.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        ext_sel       = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        case (state_r)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: alu_src_b = 2'd3;
            MEMADR, AIMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = mem_ready;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQEX: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
            end
            JEX: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            IMMWB: reg_write = 1'b1;
            LIMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 2'd3;
                ext_sel   = 1'b1;
            end
            LIMMWB: begin
                reg_write = 1'b1;
                ext_sel   = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            TRAP: illegal_op = 1'b1;
`endif
            default: illegal_op = 1'b0;
        endcase
    end

    assign instr_retired = retired_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class and checks the packed control word per cycle.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic        alu_src_a, ext_sel, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [31:0] instr_retired;
    logic [17:0] ctl_s;

    int checks_r   = 0;
    int failures_r = 0;

    // Control word: rd wr iord irw pcw pcwc pcsrc[2] a b[2] op[2] ext dst m2r rw ill
    localparam logic [17:0] W_F_RDY  = 18'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] W_F_WAIT = 18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] W_DEC    = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [17:0] W_MEMADR = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] W_MEMRD  = 18'b1_0_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] W_MEMWB  = 18'b0_0_0_0_0_0_00_0_00_00_0_0_1_1_0;
    localparam logic [17:0] W_MEMWR  = 18'b0_1_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] W_BEQEX  = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_0_0;
    localparam logic [17:0] W_JEX    = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_0_0;
    localparam logic [17:0] W_AIMMEX = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] W_IMMWB  = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [17:0] W_LIMMEX = 18'b0_0_0_0_0_0_00_1_10_11_1_0_0_0_0;
    localparam logic [17:0] W_LIMMWB = 18'b0_0_0_0_0_0_00_0_00_00_1_0_0_1_0;
    localparam logic [17:0] W_TRAP   = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_1;

    mc_control_fsm dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_sel(ext_sel),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .instr_retired(instr_retired)
    );

    assign ctl_s = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                    alu_src_a, alu_src_b, alu_op, ext_sel, reg_dst, mem_to_reg, reg_write, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: sample the control word, then advance one cycle.
    task automatic cyc(input string tag, input logic [17:0] exp);
        #1;
        check(tag, {14'd0, ctl_s}, {14'd0, exp});
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
        #1;
        check(tag, instr_retired, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h0D;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {14'd0, ctl_s}, {14'd0, W_F_RDY});
        check("rst_cnt", instr_retired, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ORI: zero-extend through execute and writeback
        cyc("ori_f", W_F_RDY);
        cyc("ori_d", W_DEC);
        cyc("ori_ex", W_LIMMEX);
        cyc("ori_wb", W_LIMMWB);
        chk_cnt("ori_cnt", 32'd1);

        // LW with a fetch stall and three wait cycles in MEMRD
        opcode    = 6'h23;
        mem_ready = 1'b0;
        cyc("f_hold", W_F_WAIT);
        mem_ready = 1'b1;
        cyc("lw_f", W_F_RDY);
        cyc("lw_d", W_DEC);
        cyc("lw_adr", W_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", W_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_rd_done", W_MEMRD);
        cyc("lw_wb", W_MEMWB);
        chk_cnt("lw_cnt", 32'd2);

        // ADDI then BEQ
        opcode = 6'h08;
        cyc("addi_f", W_F_RDY);
        cyc("addi_d", W_DEC);
        cyc("addi_ex", W_AIMMEX);
        cyc("addi_wb", W_IMMWB);
        opcode = 6'h04;
        cyc("beq_f", W_F_RDY);
        cyc("beq_d", W_DEC);
        cyc("beq_ex", W_BEQEX);
        chk_cnt("beq_cnt", 32'd4);

        // Undefined opcode
        opcode = 6'h3F;
        cyc("ill_f", W_F_RDY);
        cyc("ill_d", W_DEC);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc("ill_trap", W_TRAP);
        chk_cnt("ill_cnt", 32'd4);
        reset_n = 1'b0;
        chk_cnt("trap_rst_cnt", 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
`else
        chk_cnt("ill_cnt", 32'd5);
`endif

        // SW stalled in MEMWR, then async reset mid-access
        opcode = 6'h2B;
        cyc("sw_f", W_F_RDY);
        cyc("sw_d", W_DEC);
        cyc("sw_adr", W_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_wr", W_MEMWR);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_drop", {14'd0, ctl_s}, {14'd0, W_F_WAIT});
        chk_cnt("async_cnt", 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b1;

        // Counter wrap on a jump retirement
        opcode = 6'h02;
        cyc("j_f", W_F_RDY);
        #1;
        check("j_d", {14'd0, ctl_s}, {14'd0, W_DEC});
        force dut.retired_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_r;
        chk_cnt("preset_cnt", 32'hFFFF_FFFF);
        cyc("j_ex", W_JEX);
        chk_cnt("wrap_cnt", 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
